// File: rtl/ws_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ws_pkg
//  Description : Shared types and constants for the UDP result arbiters.
//                Holds the frame-arbiter FSM encoding, the payload byte
//                offsets and a saturating 16-bit increment helper.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package ws_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_GAP       = 3'd4
   } state_t;

   // Payload byte offsets inside a result frame
   localparam int OFS_ID   = 0;
   localparam int OFS_SEQ  = 1;
   localparam int OFS_DATA = 2;
   localparam int OFS_DROP = 6;

   localparam logic [15:0] c_DROP_MAX = 16'hFFFF;

   // Unsigned increment that sticks at all-ones
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == c_DROP_MAX) ? v : v + 16'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/udp_frame_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : udp_frame_arbiter_if
//  Description : Bus bundle between the requesters / udp_send core and the
//                frame arbiter.
//  Signals     : req, req_data      - requester strobes and 32-bit results
//                snd_start          - start pulse to udp_send
//                snd_addr           - payload byte address from udp_send
//                snd_payload        - payload byte for snd_addr
//                snd_rdy            - udp_send idle flag
//                busy, frame_cnt    - arbiter status
//  Modports    : master - requesters and udp_send side
//                slave  - arbiter side
//  Revision    : 1.0  initial release
// ============================================================================
interface udp_frame_arbiter_if #(
   parameter int NREQ = 2,
   parameter int NSZ  = 7
);
   logic [NREQ-1:0]    req;
   logic [32*NREQ-1:0] req_data;
   logic               snd_start;
   logic [NSZ-1:0]     snd_addr;
   logic [7:0]         snd_payload;
   logic               snd_rdy;
   logic               busy;
   logic [7:0]         frame_cnt;

   modport master (
      output req, req_data, snd_addr, snd_rdy,
      input  snd_start, snd_payload, busy, frame_cnt
   );

   modport slave (
      input  req, req_data, snd_addr, snd_rdy,
      output snd_start, snd_payload, busy, frame_cnt
   );
endinterface
`default_nettype wire

// File: rtl/ws_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : ws_rr_pick
//  Description : Combinational round-robin picker. Returns the first set
//                bit of pending strictly after ptr, wrapping modulo N.
//  Ports       : pending [N]  - request vector
//                ptr     [IW] - index granted last time
//                valid        - at least one pending bit set
//                idx     [IW] - granted index (0 when !valid)
//  Revision    : 1.0  initial release
// ============================================================================
module ws_rr_pick #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  pending,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   int          w_pos;
   logic [IW-1:0] w_cand;

   // Scan from the farthest candidate to the nearest one so that the last
   // hit written is the closest index after ptr.
   always_comb begin
      valid  = 1'b0;
      idx    = '0;
      w_pos  = 0;
      w_cand = '0;
      for (int k = N; k >= 1; k--) begin
         w_pos = int'(ptr) + k;
         if (w_pos >= N) begin
            w_pos = w_pos - N;
         end
         w_cand = IW'(w_pos);
         if (pending[w_cand]) begin
            valid = 1'b1;
            idx   = w_cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/udp_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : udp_frame_arbiter
//  Description : Shares one udp_send transmit path between NREQ result
//                requesters. Latches each posted result, grants one pending
//                requester round-robin, snapshots it into a frame register,
//                pulses snd_start and serves the payload bytes by address.
//                Enforces an idle gap after each frame and counts results
//                overwritten before they were sent.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                bus (slave)       - requester strobes/data, udp_send
//                                    handshake, payload and status
//  Revision    : 1.0  initial release
// ============================================================================
module udp_frame_arbiter
   import ws_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int NSZ  = 7,
   parameter int P_SZ = 18,
   parameter int GAP  = 64
) (
   input  logic              clk,
   input  logic              rst,
   udp_frame_arbiter_if.slave bus
);

   localparam int c_IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int c_GW       = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int c_GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_snd_start;
   logic              w_busy;

   logic [NREQ-1:0]   r_pending;
   logic [31:0]       r_slot [NREQ];
   logic [15:0]       r_drop [NREQ];
   logic [c_IW-1:0]   r_ptr;

   logic              w_pick_valid;
   logic [c_IW-1:0]   w_pick_idx;
   logic              w_grant;
   logic [NREQ-1:0]   w_gnt_vec;

   logic [c_IW-1:0]   r_frm_id;
   logic [31:0]       r_frm_data;
   logic [15:0]       r_frm_drop;
   logic [7:0]        r_frame_cnt;
   logic [c_GW-1:0]   r_gap_cnt;

   logic [31:0]       w_addr;
   logic [7:0]        w_payload;

   ws_rr_pick #(
      .N  (NREQ),
      .IW (c_IW)
   ) u_pick (
      .pending (r_pending),
      .ptr     (r_ptr),
      .valid   (w_pick_valid),
      .idx     (w_pick_idx)
   );

   assign w_grant = (r_state == ST_IDLE) && w_pick_valid;

   always_comb begin
      w_gnt_vec = '0;
      if (w_grant) begin
         w_gnt_vec[w_pick_idx] = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_snd_start = 1'b0;
      w_busy      = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            if (w_pick_valid) begin
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            w_snd_start = 1'b1;
            w_state_nxt = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (!bus.snd_rdy) begin
               w_state_nxt = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (bus.snd_rdy) begin
               w_state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
            end
         end
         ST_GAP: begin
            if (r_gap_cnt == c_GW'(c_GAP_LAST)) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Capture, grant snapshot and counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending   <= '0;
         r_ptr       <= c_IW'(NREQ - 1);
         r_frm_id    <= '0;
         r_frm_data  <= '0;
         r_frm_drop  <= '0;
         r_frame_cnt <= '0;
         r_gap_cnt   <= '0;
         for (int i = 0; i < NREQ; i++) begin
            r_slot[i] <= '0;
            r_drop[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_vec[i]) begin
               r_pending[i] <= 1'b0;
               r_drop[i]    <= '0;
            end
            // A strobe in the grant cycle re-arms the slot; the frame keeps
            // the value read before this edge, so it is not a drop.
            if (bus.req[i]) begin
               r_slot[i]    <= bus.req_data[32*i +: 32];
               r_pending[i] <= 1'b1;
               if (r_pending[i] && !w_gnt_vec[i]) begin
                  r_drop[i] <= sat_inc16(r_drop[i]);
               end
            end
         end

         if (w_grant) begin
            r_frm_id    <= w_pick_idx;
            r_frm_data  <= r_slot[w_pick_idx];
            r_frm_drop  <= r_drop[w_pick_idx];
            r_ptr       <= w_pick_idx;
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end

         if (r_state == ST_GAP) begin
            r_gap_cnt <= r_gap_cnt + c_GW'(1);
         end else begin
            r_gap_cnt <= '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Payload byte server
   // ------------------------------------------------------------------
   assign w_addr = 32'(bus.snd_addr);

   always_comb begin
      w_payload = 8'h00;
      if (w_addr < 32'(P_SZ)) begin
         case (w_addr)
            32'(OFS_ID):       w_payload = 8'(r_frm_id);
            32'(OFS_SEQ):      w_payload = r_frame_cnt;
            32'(OFS_DATA):     w_payload = r_frm_data[7:0];
            32'(OFS_DATA + 1): w_payload = r_frm_data[15:8];
            32'(OFS_DATA + 2): w_payload = r_frm_data[23:16];
            32'(OFS_DATA + 3): w_payload = r_frm_data[31:24];
            32'(OFS_DROP):     w_payload = r_frm_drop[7:0];
            32'(OFS_DROP + 1): w_payload = r_frm_drop[15:8];
            default:           w_payload = 8'h00;
         endcase
      end
   end

   assign bus.snd_payload = w_payload;
   assign bus.snd_start   = w_snd_start;
   assign bus.busy        = w_busy;
   assign bus.frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_udp_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_udp_frame_arbiter
//  Description : Self-checking bench for udp_frame_arbiter. Stimulus pushes
//                expected frames into a queue; a udp_send model pops and
//                compares each frame when snd_start is seen.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_udp_frame_arbiter;

   localparam int NREQ = 2;
   localparam int NSZ  = 7;
   localparam int P_SZ = 18;
   localparam int GAP  = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #20 clk = ~clk;

   udp_frame_arbiter_if #(.NREQ(NREQ), .NSZ(NSZ)) bus ();

   udp_frame_arbiter #(
      .NREQ (NREQ),
      .NSZ  (NSZ),
      .P_SZ (P_SZ),
      .GAP  (GAP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      int          id;
      logic [7:0]  seq;
      logic [31:0] data;
      logic [15:0] drop;
      int          req_cyc;
   } exp_t;

   exp_t       q[$];
   exp_t       m_e;
   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   int         busy_len = 100;
   logic       m_busy = 1'b0;
   int         m_cnt = 0;
   int         rise_cyc = 0;
   logic       have_rise = 1'b0;
   int         n_starts = 0;
   logic [7:0] seq = 8'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void push(input int id, input logic [31:0] d, input logic [15:0] dr,
                                input int rc);
      exp_t e;
      seq       = seq + 8'd1;
      e.id      = id;
      e.seq     = seq;
      e.data    = d;
      e.drop    = dr;
      e.req_cyc = rc;
      q.push_back(e);
   endfunction

   task automatic check_frame(input exp_t e);
      logic [7:0] b [8];
      b[0] = 8'(e.id);
      b[1] = e.seq;
      b[2] = e.data[7:0];
      b[3] = e.data[15:8];
      b[4] = e.data[23:16];
      b[5] = e.data[31:24];
      b[6] = e.drop[7:0];
      b[7] = e.drop[15:8];
      chk("frame_cnt", 32'(bus.frame_cnt), 32'(e.seq));
      if (e.req_cyc >= 0) chk("latency", 32'(cyc - e.req_cyc), 32'd2);
      for (int a = 0; a < 8; a++) begin
         bus.snd_addr = 7'(a);
         #1;
         chk($sformatf("byte%0d_id%0d_seq%0d", a, e.id, e.seq), 32'(bus.snd_payload), 32'(b[a]));
      end
      bus.snd_addr = 7'd8;
      #1;
      chk("byte8_zero", 32'(bus.snd_payload), 32'd0);
      bus.snd_addr = 7'(P_SZ - 1);
      #1;
      chk("byte_last_zero", 32'(bus.snd_payload), 32'd0);
      bus.snd_addr = 7'd20;
      #1;
      chk("byte20_out_of_range", 32'(bus.snd_payload), 32'd0);
      bus.snd_addr = '0;
   endtask

   // udp_send model and scoreboard monitor
   initial begin
      bus.snd_rdy  = 1'b1;
      bus.snd_addr = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_busy      = 1'b0;
            have_rise   = 1'b0;
            bus.snd_rdy = 1'b1;
         end else if (bus.snd_start) begin
            n_starts++;
            chk("start_while_frame_open", {31'b0, m_busy}, 32'd0);
            if (have_rise) chk("gap_after_rdy", {31'b0, (cyc - rise_cyc) >= GAP}, 32'd1);
            if (q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_start: got start with id byte pending, expected no frame (cycle %0d)", cyc);
            end else begin
               m_e = q.pop_front();
               check_frame(m_e);
            end
            m_busy      = 1'b1;
            m_cnt       = busy_len;
            have_rise   = 1'b0;
            bus.snd_rdy = 1'b0;
         end else if (m_busy) begin
            m_cnt--;
            if (m_cnt <= 0) begin
               bus.snd_rdy = 1'b1;
               m_busy      = 1'b0;
               rise_cyc    = cyc;
               have_rise   = 1'b1;
            end
         end
      end
   end

   task automatic strobe(input logic [NREQ-1:0] r, input logic [31:0] d0, input logic [31:0] d1,
                         output int c);
      @(posedge clk);
      #1;
      bus.req      = r;
      bus.req_data = {d1, d0};
      c            = cyc;
      @(posedge clk);
      #1;
      bus.req = '0;
   endtask

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         if (!bus.busy && !m_busy && q.size() == 0) done = 1'b1;
      end
      chk({"idle_", name}, {31'b0, done}, 32'd1);
   endtask

   task automatic wait_mbusy(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 500 && !done; i++) begin
         @(negedge clk);
         if (m_busy) done = 1'b1;
      end
      chk({"frame_open_", name}, {31'b0, done}, 32'd1);
   endtask

   task automatic wait_start(input int n);
      bit done = 1'b0;
      for (int i = 0; i < 500 && !done; i++) begin
         @(negedge clk);
         if (bus.snd_start) done = 1'b1;
      end
      chk($sformatf("start_seen_%0d", n), {31'b0, done}, 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      seq = 8'd0;
   endtask

   initial begin
      int c;
      int saved;
      bus.req      = '0;
      bus.req_data = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_start", {31'b0, bus.snd_start}, 32'd0);
      chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);

      // Single request, latency and payload map
      busy_len = 10;
      strobe(2'b01, 32'h1234_5678, 32'h0, c);
      push(0, 32'h1234_5678, 16'd0, c);
      wait_idle("t1");

      // Simultaneous requests after reset: id 0 then id 1, gap enforced
      do_reset();
      busy_len = 100;
      strobe(2'b11, 32'hAAAA_0001, 32'hBBBB_0002, c);
      push(0, 32'hAAAA_0001, 16'd0, c);
      push(1, 32'hBBBB_0002, 16'd0, -1);
      wait_idle("t2");

      // Overwrites while a frame is in flight
      busy_len = 40;
      strobe(2'b01, 32'hC0DE_0000, 32'h0, c);
      push(0, 32'hC0DE_0000, 16'd0, c);
      wait_mbusy("t3");
      strobe(2'b10, 32'h0, 32'h0000_000A, c);
      strobe(2'b10, 32'h0, 32'h0000_000B, c);
      strobe(2'b10, 32'h0, 32'h0000_000C, c);
      push(1, 32'h0000_000C, 16'd2, -1);
      wait_idle("t3a");
      strobe(2'b10, 32'h0, 32'h0000_000E, c);
      push(1, 32'h0000_000E, 16'd0, c);
      wait_idle("t3b");

      // Strobe in the exact grant cycle
      @(posedge clk);
      #1;
      bus.req      = 2'b01;
      bus.req_data = {32'h0, 32'hF1F1_F1F1};
      c            = cyc;
      @(posedge clk);
      #1;
      bus.req_data = {32'h0, 32'hF2F2_F2F2};
      @(posedge clk);
      #1;
      bus.req = '0;
      push(0, 32'hF1F1_F1F1, 16'd0, c);
      push(0, 32'hF2F2_F2F2, 16'd0, -1);
      wait_idle("t4");

      // Reset during WAIT_DONE with another request pending
      strobe(2'b01, 32'hDEAD_BEEF, 32'h0, c);
      push(0, 32'hDEAD_BEEF, 16'd0, c);
      wait_mbusy("t5");
      repeat (5) @(posedge clk);
      strobe(2'b10, 32'h0, 32'h7777_7777, c);
      do_reset();
      @(negedge clk);
      chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
      chk("midrst_start", {31'b0, bus.snd_start}, 32'd0);
      chk("midrst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
      saved = n_starts;
      repeat (150) @(negedge clk);
      chk("no_send_after_rst", 32'(n_starts), 32'(saved));
      chk("queue_empty_after_rst", 32'(q.size()), 32'd0);

      // 256 alternating frames, frame_cnt wraps
      busy_len = 3;
      strobe(2'b11, 32'h6000_0000, 32'h6000_0001, c);
      push(0, 32'h6000_0000, 16'd0, -1);
      push(1, 32'h6000_0001, 16'd0, -1);
      for (int n = 0; n < 256; n++) begin
         wait_start(n);
         if (n + 2 < 256) begin
            if (n % 2 == 0) strobe(2'b01, 32'h6000_0000 + 32'(n + 2), 32'h0, c);
            else            strobe(2'b10, 32'h0, 32'h6000_0000 + 32'(n + 2), c);
            push(n % 2, 32'h6000_0000 + 32'(n + 2), 16'd0, -1);
         end
      end
      wait_idle("t6");
      chk("frame_cnt_wrapped", 32'(bus.frame_cnt), 32'd0);
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/udp_frame_arbiter.md
Name: udp_frame_arbiter

Overview:
- Shares the single UDP transmit path (udp_send core plus RMII byte sender) between NREQ measurement requesters, such as per-channel jitter evaluators.
- Each requester posts a 32-bit result with a one-cycle strobe. The block latches the result, picks one pending requester round-robin, and snapshots it into a frame register.
- It then fires one start pulse to udp_send and serves payload bytes by address.
- It enforces a minimum inter-frame gap and counts results that were overwritten before they could be sent.

Parameters:
- NREQ, 2, number of requesters (2..8).
- NSZ, 7, width of the udp_send byte address.
- P_SZ, 18, payload size in bytes.
- GAP, 64, idle clk cycles enforced after each frame completes (0 = none).

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous active-high reset
- req  in  NREQ  per-requester result strobe, one cycle wide
- req_data  in  32*NREQ  result of requester i on bits [32i+31:32i]
- snd_start  out  1  one-cycle start pulse to udp_send
- snd_addr  in  NSZ  payload byte address from udp_send
- snd_payload  out  8  payload byte for snd_addr (combinational)
- snd_rdy  in  1  udp_send idle flag: high = idle, low = frame in progress
- busy  out  1  high whenever state != IDLE
- frame_cnt  out  8  sequence number of the last frame started

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - State = IDLE; all pending flags, slots and drop counters = 0; RR pointer = NREQ-1.
  - snd_start = 0, busy = 0, frame_cnt = 0.
  - Applies regardless of current state, including mid-frame. udp_send shares rst, so no frame is left half-owned.
- Capture, every cycle, for each requester i with req[i]=1:
  - slot[i] <= req_data[i].
  - If pending[i] was already 1 and is not being granted this cycle, drop[i] <= drop[i]+1, saturating at 16'hFFFF.
  - pending[i] <= 1.
- Grant (in IDLE only, when any pending is set):
  - Choose the first pending index after the RR pointer, wrapping modulo NREQ.
  - Same cycle: frame register <= {id, slot[id], drop[id]}; pending[id] <= 0; drop[id] <= 0; RR pointer <= id; frame_cnt <= frame_cnt+1 (wraps 255->0).
  - Go to START.
- req[id] in the grant cycle: the new data is written to the slot and pending is set again. This is not counted as a drop. The frame carries the old slot value.
- FSM:
  - IDLE: wait for any pending.
  - START: snd_start=1 for exactly 1 cycle -> WAIT_BUSY.
  - WAIT_BUSY: wait until snd_rdy=0 -> WAIT_DONE.
  - WAIT_DONE: wait until snd_rdy=1 -> GAP if GAP>0, else IDLE.
  - GAP: count GAP cycles -> IDLE.
- Latency: req strobe to snd_start = 2 cycles when IDLE with nothing else pending (capture cycle, then grant cycle, then START).
- Payload map (from the frame register, stable from grant until the next grant):
  - byte0 = requester id.
  - byte1 = frame_cnt.
  - bytes2..5 = data, little-endian.
  - bytes6..7 = drop count, little-endian.
  - bytes 8..P_SZ-1 = 0.
  - snd_addr >= P_SZ returns 0.
- Arithmetic: sequence and drop counters are unsigned; only the drop counter saturates.
- Guaranteed: no second snd_start before snd_rdy has fallen and risen again and GAP has elapsed.

Decomposition:
- Shared package ws_pkg:
  - FSM state encoding: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
  - Payload byte-offset constants: OFS_ID=0, OFS_SEQ=1, OFS_DATA=2, OFS_DROP=6.
- One sub-module: ws_rr_pick. It is a combinational round-robin priority picker that takes pending and the pointer and returns a valid flag plus the granted index. It is reused by future arbiters.

Test Plan:
- Reset, then req[0] strobe with data 32'h1234_5678:
  - snd_start exactly 2 cycles later.
  - Payload bytes 0..7 = 00,01,78,56,34,12,00,00.
- req[0] and req[1] in the same cycle, with udp_send modelled as busy for 100 cycles:
  - Frames go out for id 0 then id 1; frame_cnt reads 1 then 2.
  - A gap of at least GAP=64 cycles separates snd_rdy rising from the second snd_start.
- Three req[1] strobes while a frame is in progress, with data A, B, C:
  - The next id-1 frame carries C and drop = 2.
  - The following id-1 frame, if any, reports drop = 0.
- req[0] in the exact grant cycle of id 0:
  - The frame carries the old data and drop = 0.
  - A second id-0 frame follows with the new data.
- Assert rst during WAIT_DONE:
  - Next cycle: busy=0, snd_start=0, frame_cnt=0, no pending.
  - Nothing is sent until a new req arrives.
- 256 frames with continuous alternating requests:
  - frame_cnt wraps 255->0.
  - Grants strictly alternate 0,1,0,1.
  - snd_addr=20 returns 0.
